// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and constants.
// State encoding and port count used across the arbiter slice.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int NPORT = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports plus the memory side.
// master = requesters and memory model, slave = the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 16
);
    logic          REQ0;
    logic          REQ1;
    logic          RW0;
    logic          RW1;
    logic [AW-1:0] A0;
    logic [AW-1:0] A1;
    logic [15:0]   WD0;
    logic [15:0]   WD1;
    logic          GNT0;
    logic          GNT1;
    logic          ACK0;
    logic          ACK1;
    logic [15:0]   RD;
    logic [AW-1:0] MA;
    logic [15:0]   MD;
    logic          MRW;
    logic [15:0]   MQ;

    modport master (
        output REQ0, REQ1, RW0, RW1, A0, A1, WD0, WD1, MQ,
        input  GNT0, GNT1, ACK0, ACK1, RD, MA, MD, MRW
    );

    modport slave (
        input  REQ0, REQ1, RW0, RW1, A0, A1, WD0, WD1, MQ,
        output GNT0, GNT1, ACK0, ACK1, RD, MA, MD, MRW
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin pick with priority pointer.
// Pointer moves to the port not just served when done pulses.
module rr_arb2
    import mem_arbiter_pkg::*;
#(
    parameter int PRIO_INIT = 0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [NPORT-1:0] req,
    input  logic             done,
    input  logic             served,
    output logic             any,
    output logic             win
);

    logic prio_q;

    // Priority pointer: reset value, then hand over after each completion.
    always_ff @(posedge CK) begin
        if (RST) begin
            prio_q <= 1'(PRIO_INIT);
        end else if (done) begin
            prio_q <= ~served;
        end
    end

    // Lone requester always wins; a tie goes to the priority port.
    always_comb begin
        any = |req;
        win = prio_q;
        unique case (1'b1)
            req[0] && !req[1]: win = 1'b0;
            req[1] && !req[0]: win = 1'b1;
            default:           win = prio_q;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-memory arbiter.
// IDLE -> ISSUE -> WAIT -> ACK; one transaction every four cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int PRIO_INIT = 0,
    parameter int AW        = 16
) (
    input  logic CK,
    input  logic RST,
    mem_arbiter_if.slave bus
);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          rw_q;
    logic [AW-1:0] ma_q;
    logic [15:0]   md_q;
    logic [15:0]   rd_q;
    logic          any;
    logic          win;

    rr_arb2 #(
        .PRIO_INIT(PRIO_INIT)
    ) u_arb (
        .CK    (CK),
        .RST   (RST),
        .req   ({bus.REQ1, bus.REQ0}),
        .done  (state_q == ACK),
        .served(owner_q),
        .any   (any),
        .win   (win)
    );

    // Next state: start on any request, then walk the fixed sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched winner operands and read-data capture.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b1;
            ma_q    <= '0;
            md_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any) begin
                owner_q <= win;
                rw_q    <= win ? bus.RW1 : bus.RW0;
                ma_q    <= win ? bus.A1  : bus.A0;
                md_q    <= win ? bus.WD1 : bus.WD0;
            end
            if (state_q == WAIT && rw_q) begin
                rd_q <= bus.MQ;
            end
        end
    end

    // Grant spans ISSUE..ACK; write strobe suppressed while in reset.
    always_comb begin
        bus.GNT0 = (state_q != IDLE) && !owner_q;
        bus.GNT1 = (state_q != IDLE) &&  owner_q;
        bus.ACK0 = (state_q == ACK)  && !owner_q;
        bus.ACK1 = (state_q == ACK)  &&  owner_q;
        bus.MRW  = !((state_q == ISSUE) && !rw_q && !RST);
        bus.MA   = ma_q;
        bus.MD   = md_q;
        bus.RD   = rd_q;
    end

endmodule
